// File: rtl/ucount_disp_drv_if.sv
// Bus between the 4-bit universal counter side and its display/event consumer.
// Master: counter side (drives count and clear). Slave: ucount_disp_drv.
interface ucount_disp_drv_if #(
    parameter int unsigned WRAP_W = 8
);
    logic [3:0]        binary;
    logic              clr;
    logic [6:0]        seg;
    logic [1:0]        an;
    logic              wrap_up;
    logic              wrap_dn;
    logic              jump;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output binary, clr,
        input  seg, an, wrap_up, wrap_dn, jump, wrap_cnt
    );

    modport slave (
        input  binary, clr,
        output seg, an, wrap_up, wrap_dn, jump, wrap_cnt
    );
endinterface

// File: rtl/ucount_disp_drv.sv
// Counter consumer: BCD 2-digit multiplexed 7-segment driver plus wrap/jump event flags.
// Optional: define LEAD_ZERO_BLANK_EN to darken the tens digit when it is zero.
module ucount_disp_drv #(
    parameter int unsigned REFRESH_DIV = 4,
    parameter int unsigned WRAP_W      = 8
) (
    input logic               clk,
    input logic               reset,
    ucount_disp_drv_if.slave  bus
);
    localparam logic [15:0] DivLast = 16'(REFRESH_DIV - 1);

    logic [3:0]        bin_q, bin_d;
    logic              val_q, val_d;
    logic              sel_q, sel_d;
    logic [15:0]       div_q, div_d;
    logic              wrap_up_q, wrap_up_d;
    logic              wrap_dn_q, wrap_dn_d;
    logic              jump_q, jump_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [6:0]        seg_q, seg_d;
    logic [1:0]        an_q, an_d;

    logic [3:0] delta;
    logic       tens;
    logic [3:0] ones;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        bin_d = bus.binary;
        val_d = 1'b1;

        // Modulo-16 step size; +1 and -1 (0xF) are ordinary counting, anything else is a load.
        delta     = bus.binary - bin_q;
        wrap_up_d = val_q && (bin_q == 4'hF) && (bus.binary == 4'h0);
        wrap_dn_d = val_q && (bin_q == 4'h0) && (bus.binary == 4'hF);
        jump_d    = val_q && (delta != 4'h0) && (delta != 4'h1) && (delta != 4'hF);

        wrap_cnt_d = wrap_cnt_q;
        if (bus.clr) begin
            wrap_cnt_d = '0;
        end else if (wrap_up_q && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end

        // Refresh timing starts with the first valid sample so every slot is full length.
        div_d = div_q;
        sel_d = sel_q;
        if (val_q) begin
            if (div_q == DivLast) begin
                div_d = '0;
                sel_d = ~sel_q;
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        tens = (bin_q >= 4'd10);
        ones = tens ? (bin_q - 4'd10) : bin_q;

        // seg_q/an_q act as the digit registers: new count visible 2 cycles after it arrives.
        seg_d = '0;
        an_d  = '0;
        if (val_q) begin
            if (!sel_q) begin
                an_d  = 2'b01;
                seg_d = seg_of(ones);
            end else begin
`ifdef LEAD_ZERO_BLANK_EN
                if (tens) begin
                    an_d  = 2'b10;
                    seg_d = seg_of(4'd1);
                end
`else
                an_d  = 2'b10;
                seg_d = seg_of({3'b000, tens});
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q      <= '0;
            val_q      <= 1'b0;
            sel_q      <= 1'b0;
            div_q      <= '0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            jump_q     <= 1'b0;
            wrap_cnt_q <= '0;
            seg_q      <= '0;
            an_q       <= '0;
        end else begin
            bin_q      <= bin_d;
            val_q      <= val_d;
            sel_q      <= sel_d;
            div_q      <= div_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            jump_q     <= jump_d;
            wrap_cnt_q <= wrap_cnt_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.wrap_up  = wrap_up_q;
    assign bus.wrap_dn  = wrap_dn_q;
    assign bus.jump     = jump_q;
    assign bus.wrap_cnt = wrap_cnt_q;
endmodule
